// File: rtl/i2c_msg_scheduler.sv
// i2c_msg_scheduler: round-robin drain of per-channel I2C RX FIFOs into a framed (chan, len, payload) valid/ready byte stream
module i2c_msg_scheduler #(
  parameter int N        = 12,
  parameter int CW       = 4,
  parameter int FULL_LEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    have_msg_bus,
  input  logic [8*N-1:0]  len_bus,
  input  logic [8*N-1:0]  din_bus,
  output logic [N-1:0]    rdreq_bus,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic [CW-1:0]   cur_chan
);
  typedef enum logic [2:0] {IDLE, HDR_CH, HDR_LEN, RD, WAIT, SEND} state_t;
  state_t state;
  logic [CW-1:0] ptr;
  logic [CW-1:0] grant;
  logic [N-1:0] rot;
  logic [7:0] glen;
  logic [7:0] cnt;
  always_comb begin
    grant = '0;
    rot = N'({have_msg_bus, have_msg_bus} >> ptr);
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) grant = CW'(int'(ptr) + i >= N ? int'(ptr) + i - N : int'(ptr) + i);
    glen = len_bus[8*grant +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cur_chan <= '0;
      cnt <= '0;
      rdreq_bus <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      rdreq_bus <= '0;
      case (state)
        IDLE: if (|have_msg_bus) begin
          cur_chan <= grant;
          cnt <= glen == 8'd0 ? 8'(FULL_LEN) : glen;
          tx_data <= 8'(grant);
          tx_valid <= 1'b1;
          busy <= 1'b1;
          state <= HDR_CH;
        end
        HDR_CH: if (tx_ready) begin
          tx_data <= cnt;
          state <= HDR_LEN;
        end
        HDR_LEN: if (tx_ready) begin
          tx_valid <= 1'b0;
          rdreq_bus <= N'(1) << cur_chan;
          state <= RD;
        end
        RD: begin
          cnt <= cnt - 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          tx_data <= din_bus[8*cur_chan +: 8];
          tx_valid <= 1'b1;
          state <= SEND;
        end
        SEND: if (tx_ready) begin
          tx_valid <= 1'b0;
          if (cnt != 8'd0) begin
            rdreq_bus <= N'(1) << cur_chan;
            state <= RD;
          end else begin
            busy <= 1'b0;
            ptr <= cur_chan == CW'(N - 1) ? '0 : cur_chan + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
